spi_device: RTL and testbench

SPI_DEVICE -- requirements
Module: spi_device

---
 rtl/spi_device_pkg.sv | 42 ++++
 rtl/spi_device_fifo.sv | 55 +++++
 rtl/spi_device.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_device.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_device_pkg.sv
// Shared definitions for the SPI device: register map, CTRL/STATUS bit positions,
// FSM state encoding and the tx bit-select helpers.
package spi_device_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CPOL     = 1;
  localparam int CTRL_CPHA     = 2;
  localparam int CTRL_LSB      = 3;
  localparam int CTRL_CLEN_LSB = 4;
  localparam int CTRL_CLEN_MSB = 8;
  localparam int CTRL_IE_RX    = 9;
  localparam int CTRL_IE_TX    = 10;
  localparam int CTRL_W        = 11;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_OVF   = 2;
  localparam int STAT_TX_UNDR  = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_ABORT    = 5;

  typedef enum logic [0:0] {
    FSM_IDLE   = 1'b0,
    FSM_ACTIVE = 1'b1
  } fsm_state_e;

  // Bit that goes on the wire next; the shifter keeps the character right-aligned.
  function automatic logic tx_first_bit(input logic [31:0] word, input logic [4:0] clen,
                                        input logic lsb_first);
    return lsb_first ? word[0] : word[clen];
  endfunction

  function automatic logic [31:0] tx_advance(input logic [31:0] word, input logic lsb_first);
    return lsb_first ? (word >> 1) : (word << 1);
  endfunction

endpackage

// File: rtl/spi_device_fifo.sv
// Small synchronous FIFO used as the RX store (depth 1 = holding register).
// A pop frees a slot for a push in the same cycle, so a full FIFO accepts push+pop.
module spi_device_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SLOTS = 2 ** PTR_W;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_device.sv
// SPI device (slave) with register interface, tx buffer and rx store.
// Define SPI_DEVICE_RX_FIFO_EN for a 4-entry rx FIFO; otherwise a single holding register.
//
// state  | meaning
// IDLE   | ss deasserted or EN=0; MISO tri-stated, bit counter cleared
// ACTIVE | selected; sampling MOSI and shifting MISO on synchronized sclk edges
module spi_device
  import spi_device_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        error_o,
  output logic        intr_rx_o,
  output logic        intr_tx_o,
  input  logic        ss_i,
  input  logic        sclk_i,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe
);

  localparam logic [0:0] S_IDLE   = FSM_IDLE;
  localparam logic [0:0] S_ACTIVE = FSM_ACTIVE;

`ifdef SPI_DEVICE_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, sd_sync;
  logic ss_s, sclk_s, sd_s, ss_prev, sclk_prev;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [0:0]        state;
  logic [4:0]        bit_cnt;
  logic [31:0]       rx_shift, tx_shift, tx_buf;
  logic              tx_valid, sd_q;
  logic              rx_ovf, tx_undr, abort;
  logic [CTRL_W-1:0] ctrl;

  logic       en, cpol, cpha, lsb_first, ie_rx, ie_tx;
  logic [4:0] clen;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      sd_sync   <= '0;
      ss_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign sclk_rise = (sclk_s ^ sclk_prev) & sclk_s;
  assign sclk_fall = (sclk_s ^ sclk_prev) & ~sclk_s;

  assign en        = ctrl[CTRL_EN];
  assign cpol      = ctrl[CTRL_CPOL];
  assign cpha      = ctrl[CTRL_CPHA];
  assign lsb_first = ctrl[CTRL_LSB];
  assign clen      = ctrl[CTRL_CLEN_MSB:CTRL_CLEN_LSB];
  assign ie_rx     = ctrl[CTRL_IE_RX];
  assign ie_tx     = ctrl[CTRL_IE_TX];

  // Register decode; any errored access is fully suppressed.
  logic addr_hit, wr_err, rd_err, acc_ok;
  logic wr_ctrl, wr_status, wr_tx, rd_rx, rx_pop;
  logic [5:0] w1c;

  always_comb begin
    addr_hit = (addr_i == ADDR_CTRL) || (addr_i == ADDR_STATUS) ||
               (addr_i == ADDR_TXDATA) || (addr_i == ADDR_RXDATA);
    wr_err   = we_i && (!addr_hit || (addr_i == ADDR_RXDATA) ||
                        ((addr_i == ADDR_TXDATA) && (be_i != 4'hF)));
    rd_err   = re_i && (!addr_hit || (addr_i == ADDR_TXDATA));
  end

  assign error_o   = wr_err | rd_err;
  assign acc_ok    = !error_o;
  assign wr_ctrl   = we_i && acc_ok && (addr_i == ADDR_CTRL);
  assign wr_status = we_i && acc_ok && (addr_i == ADDR_STATUS);
  assign wr_tx     = we_i && acc_ok && (addr_i == ADDR_TXDATA);
  assign rd_rx     = re_i && acc_ok && (addr_i == ADDR_RXDATA);
  assign w1c       = (wr_status && be_i[0]) ? wdata_i[5:0] : 6'b0;

  // Edge roles: leading edge is rising for CPOL=0; CPHA=0 samples on leading.
  logic leading, trailing, start, stop, run, sample, shift, char_done, tx_load;
  logic [31:0] tx_word, rx_word, rx_head;
  logic rx_full, rx_empty, rx_ovf_set;

  assign leading   = cpol ? sclk_fall : sclk_rise;
  assign trailing  = cpol ? sclk_rise : sclk_fall;
  assign start     = (state == S_IDLE) && ss_fall && en;
  assign stop      = (state == S_ACTIVE) && (ss_rise || !en);
  assign run       = (state == S_ACTIVE) && !stop;
  assign sample    = run && (cpha ? trailing : leading);
  assign shift     = run && (cpha ? leading : trailing);
  assign char_done = sample && (bit_cnt == clen);
  assign tx_load   = start || char_done;
  assign tx_word   = tx_valid ? tx_buf : '1;
  assign rx_word   = lsb_first ? (rx_shift | ({31'b0, sd_s} << bit_cnt))
                               : {rx_shift[30:0], sd_s};
  assign rx_pop    = rd_rx && !rx_empty;
  assign rx_ovf_set = char_done && rx_full && !rx_pop;

  spi_device_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (32)
  ) u_rx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (char_done),
    .pop   (rx_pop),
    .wdata (rx_word),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl     <= '0;
      tx_buf   <= '0;
      tx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_undr  <= 1'b0;
      abort    <= 1'b0;
      state    <= S_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      sd_q     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (be_i[0]) ctrl[7:0]  <= wdata_i[7:0];
        if (be_i[1]) ctrl[10:8] <= wdata_i[10:8];
      end

      // A write coinciding with a load lands in the buffer for the next character.
      if (wr_tx) begin
        tx_buf   <= wdata_i;
        tx_valid <= 1'b1;
      end else if (tx_load) begin
        tx_valid <= 1'b0;
      end

      rx_ovf  <= rx_ovf_set | (rx_ovf & ~w1c[STAT_RX_OVF]);
      tx_undr <= (tx_load && !tx_valid) | (tx_undr & ~w1c[STAT_TX_UNDR]);
      abort   <= (stop && ss_rise && (bit_cnt != '0)) | (abort & ~w1c[STAT_ABORT]);

      if (state == S_IDLE) begin
        if (start) begin
          state    <= S_ACTIVE;
          bit_cnt  <= '0;
          rx_shift <= '0;
          if (cpha) begin
            tx_shift <= tx_word;
            sd_q     <= 1'b0;
          end else begin
            tx_shift <= tx_advance(tx_word, lsb_first);
            sd_q     <= tx_first_bit(tx_word, clen, lsb_first);
          end
        end
      end else if (stop) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        sd_q     <= 1'b0;
      end else begin
        if (sample) begin
          if (char_done) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= tx_word;
          end else begin
            bit_cnt  <= bit_cnt + 5'd1;
            rx_shift <= rx_word;
          end
        end
        if (shift) begin
          sd_q     <= tx_first_bit(tx_shift, clen, lsb_first);
          tx_shift <= tx_advance(tx_shift, lsb_first);
        end
      end
    end
  end

  logic [31:0] status_word;

  always_comb begin
    status_word                = '0;
    status_word[STAT_RX_VALID] = !rx_empty;
    status_word[STAT_TX_EMPTY] = !tx_valid;
    status_word[STAT_RX_OVF]   = rx_ovf;
    status_word[STAT_TX_UNDR]  = tx_undr;
    status_word[STAT_BUSY]     = (state == S_ACTIVE);
    status_word[STAT_ABORT]    = abort;
  end

  always_comb begin
    rdata_o = '0;
    if (re_i && acc_ok) begin
      case (addr_i)
        ADDR_CTRL:   rdata_o = 32'(ctrl);
        ADDR_STATUS: rdata_o = status_word;
        ADDR_RXDATA: rdata_o = rx_empty ? 32'h0 : rx_head;
        default:     rdata_o = '0;
      endcase
    end
  end

  assign sd_oe     = (state == S_ACTIVE);
  assign sd_o      = sd_oe & sd_q;
  assign intr_rx_o = ie_rx & !rx_empty;
  assign intr_tx_o = ie_tx & !tx_valid;

endmodule

// File: tb/tb_spi_device.sv
// Self-checking bench for spi_device: directed SPI frames driven by a bench master,
// expected MISO/RX words queued as stimulus is issued and popped at the outputs.
module tb_spi_device;

  localparam int HALF = 50;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic        error_o, intr_rx_o, intr_tx_o;
  logic        ss_i = 1'b1;
  logic        sclk_i = 1'b0;
  logic        sd_i = 1'b0;
  logic        sd_o, sd_oe;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  spi_device dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .we_i      (we_i),
    .re_i      (re_i),
    .rdata_o   (rdata_o),
    .error_o   (error_o),
    .intr_rx_o (intr_rx_o),
    .intr_tx_o (intr_tx_o),
    .ss_i      (ss_i),
    .sclk_i    (sclk_i),
    .sd_i      (sd_i),
    .sd_o      (sd_o),
    .sd_oe     (sd_oe)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    logic [31:0] v;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty");
      return 32'hDEAD_BEEF;
    end
    v = exp_q.pop_front();
    return v;
  endfunction

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic err);
    @(negedge clk_i);
    addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1;
    #1 err = error_o;
    @(negedge clk_i);
    we_i = 1'b0; be_i = '0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge clk_i);
    addr_i = a; re_i = 1'b1;
    #1 d = rdata_o; err = error_o;
    @(negedge clk_i);
    re_i = 1'b0;
  endtask

  task automatic spi_xfer(input logic cpol, input logic cpha, input logic lsb, input int nbits,
                          input logic [31:0] mosi, output logic [31:0] miso);
    int idx, nidx;
    miso = '0;
    sclk_i = cpol;
    #(HALF);
    if (!cpha) sd_i = mosi[lsb ? 0 : nbits - 1];
    ss_i = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      idx  = lsb ? i : nbits - 1 - i;
      nidx = lsb ? i + 1 : nbits - 2 - i;
      if (cpha) begin
        sclk_i = ~cpol; sd_i = mosi[idx];
        #(HALF);
        sclk_i = cpol; miso[idx] = sd_o;
        #(HALF);
      end else begin
        sclk_i = ~cpol; miso[idx] = sd_o;
        #(HALF);
        sclk_i = cpol;
        if (i + 1 < nbits) sd_i = mosi[nidx];
        #(HALF);
      end
    end
    ss_i = 1'b1;
    #(2 * HALF);
  endtask

  logic [31:0] rd, miso;
  logic        err;

  initial begin
    // Reset state, sampled while reset is still asserted.
    #23;
    check_eq("rst_sd_oe", 32'(sd_oe), 32'h0);
    check_eq("rst_sd_o", 32'(sd_o), 32'h0);
    check_eq("rst_intr", {30'b0, intr_rx_o, intr_tx_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b0;
    reg_rd(8'h04, rd, err); check_eq("rst_status", rd, 32'h02);
    reg_rd(8'h00, rd, err); check_eq("rst_ctrl", rd, 32'h0);

    // Mode 0, MSB first, 8-bit character.
    reg_wr(8'h00, 32'h071, 4'hF, err);
    reg_wr(8'h08, 32'hA5, 4'hF, err); check_eq("tx_wr_err", 32'(err), 32'h0);
    reg_rd(8'h04, rd, err); check_eq("m0_status_pre", rd, 32'h00);
    exp_q.push_back(32'hA5); exp_q.push_back(32'h3C);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 32'h3C, miso);
    check_eq("m0_miso", miso, pop_exp());
    check_eq("m0_intr_rx_off", 32'(intr_rx_o), 32'h0);
    reg_wr(8'h00, 32'h271, 4'hF, err);
    #1 check_eq("m0_intr_rx_on", 32'(intr_rx_o), 32'h1);
    reg_rd(8'h0C, rd, err); check_eq("m0_rxdata", rd, pop_exp());
    #1 check_eq("m0_intr_rx_pop", 32'(intr_rx_o), 32'h0);
    reg_wr(8'h00, 32'h471, 4'h3, err);
    #1 check_eq("m0_intr_tx", 32'(intr_tx_o), 32'h1);

    // Mode 3, LSB first, 16-bit character.
    reg_wr(8'h04, 32'h2C, 4'hF, err);
    reg_wr(8'h00, 32'h0FF, 4'hF, err);
    reg_wr(8'h08, 32'h1234, 4'hF, err);
    exp_q.push_back(32'h1234); exp_q.push_back(32'h0000BEEF);
    spi_xfer(1'b1, 1'b1, 1'b1, 16, 32'hBEEF, miso);
    check_eq("m3_miso", miso, pop_exp());
    reg_rd(8'h0C, rd, err); check_eq("m3_rxdata", rd, pop_exp());

    // Two characters, no tx writes and no pops in between.
    reg_wr(8'h04, 32'h2C, 4'hF, err);
    reg_wr(8'h00, 32'h071, 4'hF, err);
    exp_q.push_back(32'hFF); exp_q.push_back(32'hFF);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 32'h11, miso);
    check_eq("un_miso0", miso, pop_exp());
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 32'h22, miso);
    check_eq("un_miso1", miso, pop_exp());
`ifdef SPI_DEVICE_RX_FIFO_EN
    exp_q.push_back(32'h0B); exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    reg_rd(8'h04, rd, err); check_eq("un_status", rd, pop_exp());
    reg_rd(8'h0C, rd, err); check_eq("un_rx0", rd, pop_exp());
    reg_rd(8'h0C, rd, err); check_eq("un_rx1", rd, pop_exp());
`else
    exp_q.push_back(32'h0F); exp_q.push_back(32'h11);
    reg_rd(8'h04, rd, err); check_eq("un_status", rd, pop_exp());
    reg_rd(8'h0C, rd, err); check_eq("un_rx0", rd, pop_exp());
`endif
    reg_rd(8'h04, rd, err); check_eq("un_rx_empty", rd & 32'h1, 32'h0);

    // Abort after 3 of 8 bits.
    reg_wr(8'h04, 32'h2C, 4'hF, err);
    spi_xfer(1'b0, 1'b0, 1'b0, 3, 32'h5, miso);
    reg_rd(8'h04, rd, err); check_eq("ab_status", rd & 32'h21, 32'h20);
    reg_wr(8'h04, 32'h20, 4'hF, err);
    reg_rd(8'h04, rd, err); check_eq("ab_clear", rd & 32'h20, 32'h0);

    // Errored accesses: flagged and without effect.
    reg_rd(8'h08, rd, err); check_eq("er_rd_tx", 32'(err), 32'h1);
    check_eq("er_rd_tx_data", rd, 32'h0);
    reg_wr(8'h0C, 32'hFFFF_FFFF, 4'hF, err); check_eq("er_wr_rx", 32'(err), 32'h1);
    reg_wr(8'h10, 32'hFFFF_FFFF, 4'hF, err); check_eq("er_wr_unmap", 32'(err), 32'h1);
    reg_wr(8'h08, 32'h77, 4'h1, err); check_eq("er_tx_be", 32'(err), 32'h1);
    reg_rd(8'h04, rd, err); check_eq("er_status", rd, 32'h0A);
    check_eq("er_ok_access", 32'(err), 32'h0);
    reg_rd(8'h00, rd, err); check_eq("er_ctrl", rd, 32'h071);

    // Reset in the middle of a character.
    reg_wr(8'h08, 32'h55, 4'hF, err);
    sclk_i = 1'b0; sd_i = 1'b1;
    #(HALF); ss_i = 1'b0;
    #(HALF); sclk_i = 1'b1;
    #(HALF); sclk_i = 1'b0;
    #(HALF);
    check_eq("rs_active", 32'(sd_oe), 32'h1);
    rst_i = 1'b1;
    #1 check_eq("rs_sd_oe", {30'b0, sd_oe, sd_o}, 32'h0);
    ss_i = 1'b1;
    #(HALF);
    @(negedge clk_i); rst_i = 1'b0;
    reg_rd(8'h04, rd, err); check_eq("rs_status", rd, 32'h02);
    reg_rd(8'h00, rd, err); check_eq("rs_ctrl", rd, 32'h0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
